// File: rtl/fifo_rr_read_arbiter.sv
// fifo_rr_read_arbiter
// Round-robin read scheduler for N_CH upstream FIFOs with 1-cycle registered
// read data. The granted FIFO is drained in bursts of up to MAX_BURST words
// into a single Avalon-ST source tagged with the originating channel. A
// 2-entry skid buffer absorbs the FIFO read latency so a steady grant
// sustains one word per cycle under src_ready_i backpressure.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   enable_i           allows arbitration and new FIFO reads
//   fifo_non_empty_i   per-FIFO non-empty flags
//   fifo_rd_o          per-FIFO read strobe (one-hot or zero)
//   fifo_data_i        per-FIFO read data, channel k at [k*WIDTH +: WIDTH]
//   src_*              Avalon-ST source (data, channel, valid, ready)
//   busy_o             grant held, read in flight, or skid buffer occupied
//
// States
//   ST_ARB   | pick next non-empty FIFO after last_grant; no read issued
//   ST_GRANT | read granted FIFO while credit allows, up to MAX_BURST words

module fifo_rr_read_arbiter #(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4,
  parameter int CH_W      = $clog2(N_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [N_CH-1:0]         fifo_non_empty_i,
  output logic [N_CH-1:0]         fifo_rd_o,
  input  logic [N_CH*WIDTH-1:0]   fifo_data_i,
  output logic [WIDTH-1:0]        src_data_o,
  output logic [CH_W-1:0]         src_channel_o,
  output logic                    src_valid_o,
  input  logic                    src_ready_i,
  output logic                    busy_o
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CH_W-1:0]  last_grant_q, last_grant_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic             inflight_q, inflight_d;
  logic [CH_W-1:0]  inflight_tag_q, inflight_tag_d;

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [CH_W-1:0]  chan0_q, chan0_d, chan1_q, chan1_d;

  logic             pick_valid;
  logic [CH_W-1:0]  pick;
  logic             pop;
  logic             push;
  logic [2:0]       level;
  logic             credit_ok;
  logic             issue;
  logic             burst_last;
  logic [WIDTH-1:0] push_data;

  // Round-robin search starting at last_grant+1. Iterating from the farthest
  // candidate down means the nearest set bit is the last assignment.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick       = last_grant_q;
    for (int i = N_CH; i >= 1; i--) begin
      idx = (int'(last_grant_q) + i) % N_CH;
      if (fifo_non_empty_i[idx]) begin
        pick_valid = 1'b1;
        pick       = CH_W'(idx);
      end
    end
  end

  assign pop  = src_valid_o & src_ready_i;
  assign push = inflight_q;

  // Credit: words already owed to the skid buffer (buffered plus in flight),
  // less the one leaving this cycle, must stay below its depth of two.
  assign level     = {1'b0, occ_q} + {2'b00, inflight_q};
  assign credit_ok = level < (3'd2 + {2'b00, pop});

  assign issue = !rst_i && (state_q == ST_GRANT) && enable_i &&
                 fifo_non_empty_i[grant_q] && credit_ok;

  assign burst_last = (burst_cnt_q == BC_W'(MAX_BURST - 1));

  always_comb begin
    fifo_rd_o = '0;
    if (issue) fifo_rd_o[grant_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (enable_i && pick_valid) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = ST_GRANT;
        end
      end
      default: begin
        if (issue) burst_cnt_d = burst_cnt_q + BC_W'(1);
        // A stall caused only by missing credit keeps the grant.
        if ((issue && burst_last) || !fifo_non_empty_i[grant_q] || !enable_i) begin
          state_d      = ST_ARB;
          last_grant_d = grant_q;
        end
      end
    endcase
  end

  assign inflight_d     = issue;
  assign inflight_tag_d = issue ? grant_q : inflight_tag_q;
  assign push_data      = fifo_data_i[int'(inflight_tag_q)*WIDTH +: WIDTH];

  // In-order skid buffer; entry 0 is the head presented on the source.
  always_comb begin
    occ_d   = occ_q;
    data0_d = data0_q;
    chan0_d = chan0_q;
    data1_d = data1_q;
    chan1_d = chan1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = push_data;
          chan0_d = inflight_tag_q;
        end else begin
          data1_d = push_data;
          chan1_d = inflight_tag_q;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        chan0_d = chan1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          data0_d = push_data;
          chan0_d = inflight_tag_q;
        end else begin
          data0_d = data1_q;
          chan0_d = chan1_q;
          data1_d = push_data;
          chan1_d = inflight_tag_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_ARB;
      last_grant_q   <= CH_W'(N_CH - 1);
      grant_q        <= '0;
      burst_cnt_q    <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
      occ_q          <= 2'd0;
      data0_q        <= '0;
      chan0_q        <= '0;
      data1_q        <= '0;
      chan1_q        <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      burst_cnt_q    <= burst_cnt_d;
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
      occ_q          <= occ_d;
      data0_q        <= data0_d;
      chan0_q        <= chan0_d;
      data1_q        <= data1_d;
      chan1_q        <= chan1_d;
    end
  end

  assign src_valid_o   = (occ_q != 2'd0);
  assign src_data_o    = data0_q;
  assign src_channel_o = chan0_q;
  assign busy_o        = (state_q == ST_GRANT) | inflight_q | (occ_q != 2'd0);

endmodule
